// File: rtl/led_pattern_gen_if.sv
// Control/status bundle between the LED pattern source and its consumers:
// the run enable going in, the tick strobe and both waveforms coming out.
interface led_pattern_gen_if;
  logic enable;
  logic tick;
  logic pattern1;
  logic pattern2;

  modport master (
    output enable,
    input  tick,
    input  pattern1,
    input  pattern2
  );

  modport slave (
    input  enable,
    output tick,
    output pattern1,
    output pattern2
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Shared LED pattern source: a prescaled time-base tick, a 50% blink on
// pattern1 and a double-pulse heartbeat on pattern2. Every output is a register.
module led_pattern_gen #(
  parameter int TICK_DIV     = 12000,
  parameter int BLINK_TICKS  = 500,
  parameter int PULSE_TICKS  = 100,
  parameter int GAP_TICKS    = 150,
  parameter int PERIOD_TICKS = 1000
) (
  input  logic              clk,
  input  logic              rst,
  led_pattern_gen_if.slave  bus
);
  localparam int REST_TICKS = PERIOD_TICKS - 2*PULSE_TICKS - GAP_TICKS;
  localparam int PG_MAX     = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
  localparam int PH_MAX     = (PG_MAX > REST_TICKS) ? PG_MAX : REST_TICKS;
  localparam int PS_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BL_W       = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int PH_W       = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PS_W-1:0] PS_LAST    = PS_W'(TICK_DIV - 1);
  localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_TICKS - 1);
  localparam logic [PH_W-1:0] PULSE_LAST = PH_W'(PULSE_TICKS - 1);
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(GAP_TICKS - 1);
  localparam logic [PH_W-1:0] REST_LAST  = PH_W'(REST_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PULSE1 = 3'd1,
    S_GAP    = 3'd2,
    S_PULSE2 = 3'd3,
    S_REST   = 3'd4
  } state_t;

  logic [PS_W-1:0] r_prescaler;
  logic            r_tick;
  logic [BL_W-1:0] r_blink_cnt;
  logic            r_pattern1;
  logic [PH_W-1:0] r_phase;
  state_t          r_state;
  logic            r_pattern2;

  // tick is registered from the prescaler's terminal count, one clock wide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescaler <= '0;
      r_tick      <= 1'b0;
    end else if (!bus.enable) begin
      r_prescaler <= '0;
      r_tick      <= 1'b0;
    end else begin
      r_tick      <= (r_prescaler == PS_LAST);
      r_prescaler <= (r_prescaler == PS_LAST) ? '0 : r_prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_pattern1  <= 1'b0;
    end else if (!bus.enable) begin
      r_blink_cnt <= '0;
      r_pattern1  <= 1'b0;
    end else if (r_tick) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_pattern1  <= ~r_pattern1;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // pattern2 is loaded alongside each state change so it follows the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_pattern2 <= 1'b0;
    end else if (!bus.enable || r_state > S_REST) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_pattern2 <= 1'b0;
    end else if (r_tick) begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_PULSE1;
          r_phase    <= '0;
          r_pattern2 <= 1'b1;
        end
        S_PULSE1: begin
          if (r_phase == PULSE_LAST) begin
            r_state    <= S_GAP;
            r_phase    <= '0;
            r_pattern2 <= 1'b0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_GAP: begin
          if (r_phase == GAP_LAST) begin
            r_state    <= S_PULSE2;
            r_phase    <= '0;
            r_pattern2 <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_PULSE2: begin
          if (r_phase == PULSE_LAST) begin
            r_state    <= S_REST;
            r_phase    <= '0;
            r_pattern2 <= 1'b0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_REST: begin
          if (r_phase == REST_LAST) begin
            r_state    <= S_PULSE1;
            r_phase    <= '0;
            r_pattern2 <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_phase    <= '0;
          r_pattern2 <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tick     = r_tick;
  assign bus.pattern1 = r_pattern1;
  assign bus.pattern2 = r_pattern2;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: nominal heartbeat (PERIOD 8) and the
// minimum-REST corner (PERIOD 6) run side by side from the same clock/reset.
module tb_led_pattern_gen;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  led_pattern_gen_if bus_a ();
  led_pattern_gen_if bus_b ();

  led_pattern_gen #(
    .TICK_DIV(4), .BLINK_TICKS(3), .PULSE_TICKS(2), .GAP_TICKS(1), .PERIOD_TICKS(8)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  led_pattern_gen #(
    .TICK_DIV(4), .BLINK_TICKS(3), .PULSE_TICKS(2), .GAP_TICKS(1), .PERIOD_TICKS(6)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Expected levels right after edge n (edges counted from the run start)
  function automatic logic exp_tick(input int n);
    return (n >= 4) && (n % 4 == 0);
  endfunction

  function automatic logic exp_p1(input int n);
    if (n < 13) return 1'b0;
    return (((n - 13) / 12) % 2) == 0;
  endfunction

  // Heartbeat cycle in clocks is 4*PERIOD_TICKS; pulses at [0,8) and [12,20)
  function automatic logic exp_p2(input int n, input int cyc);
    int m;
    if (n < 5) return 1'b0;
    m = (n - 5) % cyc;
    return (m < 8) || (m >= 12 && m < 20);
  endfunction

  task automatic set_enable(input logic v);
    bus_a.enable = v;
    bus_b.enable = v;
  endtask

  task automatic start_run();
    rst = 1'b1;
    set_enable(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_enable(1'b1);
  endtask

  task automatic run_window(input string ph, input int last);
    for (int n = 1; n <= last; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s tick e%0d", ph, n),    32'(bus_a.tick),     32'(exp_tick(n)));
      check($sformatf("%s p1 e%0d", ph, n),      32'(bus_a.pattern1), 32'(exp_p1(n)));
      check($sformatf("%s p2 e%0d", ph, n),      32'(bus_a.pattern2), 32'(exp_p2(n, 32)));
      check($sformatf("%s tickB e%0d", ph, n),   32'(bus_b.tick),     32'(exp_tick(n)));
      check($sformatf("%s p2min e%0d", ph, n),   32'(bus_b.pattern2), 32'(exp_p2(n, 24)));
    end
    $display("window %s: %0d edges checked", ph, last);
  endtask

  task automatic check_all_zero(input string ph);
    check({ph, " tick"},  32'(bus_a.tick),     32'd0);
    check({ph, " p1"},    32'(bus_a.pattern1), 32'd0);
    check({ph, " p2"},    32'(bus_a.pattern2), 32'd0);
    check({ph, " tickB"}, 32'(bus_b.tick),     32'd0);
    check({ph, " p1B"},   32'(bus_b.pattern1), 32'd0);
    check({ph, " p2B"},   32'(bus_b.pattern2), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    set_enable(1'b0);
    #2;
    check_all_zero("reset");

    // Full nominal sequence: two pattern1 periods, more than two heartbeats
    start_run();
    run_window("run", 80);

    // Enable drop after edge 20, clear on edge 21, then restart
    start_run();
    run_window("pre_drop", 20);
    set_enable(1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_all_zero($sformatf("drop e%0d", 21 + k));
    end
    @(negedge clk);
    set_enable(1'b1);
    run_window("restart", 80);

    // Async reset mid-cycle while tick, pattern1 and pattern2 are all high
    start_run();
    run_window("pre_rst", 20);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    check_all_zero("rst_held");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Upstream pattern source for the per-LED output selector, which picks between off, on, pattern1 and pattern2 using a 2-bit state.
- Derives a slow time-base tick from the system clock.
- From that tick, generates two registered LED waveforms:
  - pattern1: a 50% square-wave blink.
  - pattern2: a double-pulse heartbeat.
- One instance is shared by all LED selectors. All outputs are glitch-free registers.

Parameters:
- TICK_DIV, 12000: system clocks per time-base tick. Minimum 2.
- BLINK_TICKS, 500: ticks per pattern1 half-period. Minimum 1.
- PULSE_TICKS, 100: ticks per heartbeat pulse (high phase). Minimum 1.
- GAP_TICKS, 150: ticks between the two heartbeat pulses (low). Minimum 1.
- PERIOD_TICKS, 1000: heartbeat period in ticks, counted from the first pulse start. Must be at least 2*PULSE_TICKS+GAP_TICKS+1.

Ports:
- clk, input, 1: system clock; all logic is on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- enable, input, 1: synchronous run enable. Low clears and holds the block.
- tick, output, 1: registered one-clock time-base strobe.
- pattern1, output, 1: square-wave blink.
- pattern2, output, 1: heartbeat waveform.

Behaviour:
- Reset, and every clock with enable low:
  - prescaler = 0, tick = 0, pattern1 = 0, pattern2 = 0.
  - Blink counter = 0, phase counter = 0, FSM = IDLE.
  - Reset acts asynchronously; the enable-low clear is synchronous and has the same effect.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is registered as (prescaler == TICK_DIV-1), so it is high for exactly one clock per TICK_DIV clocks.
  - The first tick is visible after TICK_DIV rising edges with enable high.
- All pattern logic advances only on an edge where registered tick is sampled high. Pattern outputs therefore change 1 clock after tick is visible.
- Counter widths are $clog2 of the respective parameter (minimum 1 bit). Wrap is explicit compare-and-clear, never modulo-2^n.
- pattern1:
  - The blink counter increments on each sampled tick.
  - When it equals BLINK_TICKS-1: pattern1 toggles and the counter clears.
  - Period is 2*BLINK_TICKS ticks.
- pattern2 FSM states: IDLE, PULSE1, GAP, PULSE2, REST.
  - IDLE goes to PULSE1 on the first sampled tick.
  - Each subsequent state holds for its duration in sampled ticks, tracked by a phase counter. The counter is cleared on entry; on the tick where it equals duration-1, the FSM advances and the counter clears.
  - Durations: PULSE1 = PULSE_TICKS, GAP = GAP_TICKS, PULSE2 = PULSE_TICKS, REST = PERIOD_TICKS-2*PULSE_TICKS-GAP_TICKS.
  - REST returns to PULSE1, never to IDLE.
  - pattern2 is registered from the next state: 1 when next state is PULSE1 or PULSE2, else 0. It changes on the same edge as the state.
- The prescaler runs regardless of FSM state. The blink and heartbeat sequences are independent and share only tick.
- Mid-operation events:
  - enable deasserted: everything clears on the next edge.
  - enable reasserted: both sequences restart from their reset phase.
  - Async reset: clears immediately regardless of clk.
- Illegal FSM encodings recover to IDLE with pattern2 = 0.

Test Plan:
Bench parameters: TICK_DIV=4, BLINK_TICKS=3, PULSE_TICKS=2, GAP_TICKS=1, PERIOD_TICKS=8, giving REST = 3. Edges are counted from the first rising edge after rst falls, with enable high throughout.

1. Reset values: assert rst mid-cycle with outputs active -> tick, pattern1 and pattern2 are all 0 immediately, without waiting for a clk edge.
2. Tick timing: tick is high after edges 4, 8, 12, ..., exactly 1 clock wide, and low otherwise.
3. pattern1: rises at edge 13, falls at edge 25, rises at edge 37. Period is 24 clocks with a 50% duty cycle.
4. pattern2 sequence:
   - high on edges 5–13 (PULSE1)
   - low on edges 13–17 (GAP)
   - high on edges 17–25 (PULSE2)
   - low on edges 25–37 (REST)
   - high again at edge 37; repeats every 32 clocks thereafter.
5. Enable drop and restart: drop enable at edge 20 -> all outputs and the prescaler are 0 at edge 21. Re-raise enable -> the step 2–4 timing repeats relative to the new start edge.
6. Minimum-REST corner: set PERIOD_TICKS=6 (REST = 1 tick) -> PULSE1 is re-entered exactly 1 tick after PULSE2 ends, with no extra idle tick.
